logic_74hc191_updown: RTL and testbench



---
 rtl/logic_74hc191_updown.sv | 88 ++++++++
 tb/tb_logic_74hc191_updown.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_74hc191_updown.sv
// 74HC191-style synchronous up/down binary counter with parallel load.
// Latency: one CK edge from control change to COUNTER; MAXMIN/nRCO are combinational.
// Backpressure: none; nCTEN gates counting, and nRCO feeds a downstream stage's nCTEN.
// Optional: define LOGIC_74HC191_STICKY_WRAP_EN to add the registered sticky WRAP output.
module logic_74hc191_updown #(
    parameter int WIDTH = 4
) (
    input  logic             CK,
    input  logic             CLR,
    input  logic             nLOAD,
    input  logic             nCTEN,
    input  logic             DnUP,
    input  logic [WIDTH-1:0] DATAIN,
    output logic [WIDTH-1:0] COUNTER,
    output logic             MAXMIN,
    output logic             nRCO
`ifdef LOGIC_74HC191_STICKY_WRAP_EN
    ,
    output logic             WRAP
`endif
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             count_en;
    logic             at_term;

    // Terminal count depends on the live direction, so MAXMIN flips with DnUP without a clock.
    always_comb begin
        at_term  = DnUP ? (count_q == ALL_ZERO) : (count_q == ALL_ONES);
        count_en = ~nCTEN;
    end

    // Next-state: clear beats load, load beats count; otherwise hold.
    always_comb begin
        count_d = count_q;
        if (CLR) begin
            count_d = ALL_ZERO;
        end else if (!nLOAD) begin
            count_d = DATAIN;
        end else if (count_en) begin
            count_d = DnUP ? (count_q - ONE) : (count_q + ONE);
        end
    end

    // Count register with synchronous active-high clear.
    always_ff @(posedge CK) begin
        count_q <= count_d;
    end

    // Outputs: nRCO is asserted only while terminal and enabled, so the next stage
    // counts on the same edge at which this stage wraps.
    always_comb begin
        COUNTER = count_q;
        MAXMIN  = at_term;
        nRCO    = ~(at_term & count_en);
    end

`ifdef LOGIC_74HC191_STICKY_WRAP_EN
    logic wrap_q;
    logic wrap_d;

    // Sticky wrap: set by a counting wrap, cleared by clear or load (clear/load win).
    always_comb begin
        wrap_d = wrap_q;
        if (CLR || !nLOAD) begin
            wrap_d = 1'b0;
        end else if (count_en && at_term) begin
            wrap_d = 1'b1;
        end
    end

    // Wrap flag register.
    always_ff @(posedge CK) begin
        wrap_q <= wrap_d;
    end

    // Drive the registered flag onto the port.
    always_comb begin
        WRAP = wrap_q;
    end
`endif

endmodule

// File: tb/tb_logic_74hc191_updown.sv
// Directed self-checking bench for logic_74hc191_updown, including a two-stage cascade.
// Inputs change #1 after a rising edge; outputs are checked in the same window.
// Expected values are hand-computed constants per scenario.
module tb_logic_74hc191_updown;

    logic       CK;
    logic       CLR, nLOAD, nCTEN, DnUP;
    logic [3:0] DATAIN;
    logic [3:0] COUNTER;
    logic       MAXMIN, nRCO;

    // cascade stimulus / observation
    logic       c_clr, c_load, c_cten, c_dnup;
    logic [7:0] c_data;
    logic [3:0] c1_cnt, c2_cnt;
    logic       c1_mm, c1_rco, c2_mm, c2_rco;

    int checks;
    int errors;

`ifdef LOGIC_74HC191_STICKY_WRAP_EN
    logic WRAP, c1_wrap, c2_wrap;
`endif

    logic_74hc191_updown #(.WIDTH(4)) dut (
        .CK(CK), .CLR(CLR), .nLOAD(nLOAD), .nCTEN(nCTEN), .DnUP(DnUP),
        .DATAIN(DATAIN), .COUNTER(COUNTER), .MAXMIN(MAXMIN), .nRCO(nRCO)
`ifdef LOGIC_74HC191_STICKY_WRAP_EN
        , .WRAP(WRAP)
`endif
    );

    logic_74hc191_updown #(.WIDTH(4)) stage1 (
        .CK(CK), .CLR(c_clr), .nLOAD(c_load), .nCTEN(c_cten), .DnUP(c_dnup),
        .DATAIN(c_data[3:0]), .COUNTER(c1_cnt), .MAXMIN(c1_mm), .nRCO(c1_rco)
`ifdef LOGIC_74HC191_STICKY_WRAP_EN
        , .WRAP(c1_wrap)
`endif
    );

    logic_74hc191_updown #(.WIDTH(4)) stage2 (
        .CK(CK), .CLR(c_clr), .nLOAD(c_load), .nCTEN(c1_rco), .DnUP(c_dnup),
        .DATAIN(c_data[7:4]), .COUNTER(c2_cnt), .MAXMIN(c2_mm), .nRCO(c2_rco)
`ifdef LOGIC_74HC191_STICKY_WRAP_EN
        , .WRAP(c2_wrap)
`endif
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        DnUP = 1'b1; nCTEN = 1'b1; nLOAD = 1'b1; CLR = 1'b1; DATAIN = 4'h3;
        step();
        checks++; if (COUNTER !== 4'h0) begin errors++; $display("FAIL reset_count actual=%h expected=0", COUNTER); end
        checks++; if (MAXMIN !== 1'b1) begin errors++; $display("FAIL reset_maxmin actual=%b expected=1", MAXMIN); end
        checks++; if (nRCO !== 1'b1) begin errors++; $display("FAIL reset_nrco actual=%b expected=1", nRCO); end
        nCTEN = 1'b0; #1;
        checks++; if (nRCO !== 1'b0) begin errors++; $display("FAIL reset_nrco_en actual=%b expected=0", nRCO); end
`ifdef LOGIC_74HC191_STICKY_WRAP_EN
        checks++; if (WRAP !== 1'b0) begin errors++; $display("FAIL reset_wrap actual=%b expected=0", WRAP); end
`endif
        CLR = 1'b0; nLOAD = 1'b0; DATAIN = 4'h9;
        step();
        checks++; if (COUNTER !== 4'h9) begin errors++; $display("FAIL load9 actual=%h expected=9", COUNTER); end
        checks++; if (MAXMIN !== 1'b0) begin errors++; $display("FAIL load9_maxmin actual=%b expected=0", MAXMIN); end
    endtask

    task automatic test_up_wrap();
        DnUP = 1'b0; nCTEN = 1'b1; nLOAD = 1'b0; DATAIN = 4'hE;
        step();
        checks++; if (COUNTER !== 4'hE) begin errors++; $display("FAIL up_loadE actual=%h expected=E", COUNTER); end
        nLOAD = 1'b1; nCTEN = 1'b0; #1;
        checks++; if ({MAXMIN, nRCO} !== 2'b01) begin errors++; $display("FAIL up_E_flags actual=%b expected=01", {MAXMIN, nRCO}); end
        step();
        checks++; if (COUNTER !== 4'hF) begin errors++; $display("FAIL up_F actual=%h expected=F", COUNTER); end
        checks++; if ({MAXMIN, nRCO} !== 2'b10) begin errors++; $display("FAIL up_F_flags actual=%b expected=10", {MAXMIN, nRCO}); end
`ifdef LOGIC_74HC191_STICKY_WRAP_EN
        checks++; if (WRAP !== 1'b0) begin errors++; $display("FAIL up_F_wrap actual=%b expected=0", WRAP); end
`endif
        step();
        checks++; if (COUNTER !== 4'h0) begin errors++; $display("FAIL up_0 actual=%h expected=0", COUNTER); end
        checks++; if ({MAXMIN, nRCO} !== 2'b01) begin errors++; $display("FAIL up_0_flags actual=%b expected=01", {MAXMIN, nRCO}); end
`ifdef LOGIC_74HC191_STICKY_WRAP_EN
        checks++; if (WRAP !== 1'b1) begin errors++; $display("FAIL up_0_wrap actual=%b expected=1", WRAP); end
`endif
        step();
        checks++; if (COUNTER !== 4'h1) begin errors++; $display("FAIL up_1 actual=%h expected=1", COUNTER); end
`ifdef LOGIC_74HC191_STICKY_WRAP_EN
        checks++; if (WRAP !== 1'b1) begin errors++; $display("FAIL up_1_wrap actual=%b expected=1", WRAP); end
`endif
    endtask

    task automatic test_down_wrap();
        DnUP = 1'b1; nCTEN = 1'b1; nLOAD = 1'b0; DATAIN = 4'h1;
        step();
        checks++; if (COUNTER !== 4'h1) begin errors++; $display("FAIL dn_load1 actual=%h expected=1", COUNTER); end
`ifdef LOGIC_74HC191_STICKY_WRAP_EN
        checks++; if (WRAP !== 1'b0) begin errors++; $display("FAIL dn_load_clears_wrap actual=%b expected=0", WRAP); end
`endif
        nLOAD = 1'b1; nCTEN = 1'b0;
        step();
        checks++; if (COUNTER !== 4'h0) begin errors++; $display("FAIL dn_0 actual=%h expected=0", COUNTER); end
        checks++; if ({MAXMIN, nRCO} !== 2'b10) begin errors++; $display("FAIL dn_0_flags actual=%b expected=10", {MAXMIN, nRCO}); end
        nCTEN = 1'b1; #1;
        checks++; if ({MAXMIN, nRCO} !== 2'b11) begin errors++; $display("FAIL dn_0_disabled actual=%b expected=11", {MAXMIN, nRCO}); end
        nCTEN = 1'b0;
        step();
        checks++; if (COUNTER !== 4'hF) begin errors++; $display("FAIL dn_F actual=%h expected=F", COUNTER); end
        checks++; if (nRCO !== 1'b1) begin errors++; $display("FAIL dn_F_nrco actual=%b expected=1", nRCO); end
`ifdef LOGIC_74HC191_STICKY_WRAP_EN
        checks++; if (WRAP !== 1'b1) begin errors++; $display("FAIL dn_F_wrap actual=%b expected=1", WRAP); end
`endif
        step();
        checks++; if (COUNTER !== 4'hE) begin errors++; $display("FAIL dn_E actual=%h expected=E", COUNTER); end
    endtask

    task automatic test_priority();
        DnUP = 1'b0; nCTEN = 1'b1; nLOAD = 1'b0; DATAIN = 4'h5;
        step();
        checks++; if (COUNTER !== 4'h5) begin errors++; $display("FAIL pri_load5 actual=%h expected=5", COUNTER); end
        CLR = 1'b1; nLOAD = 1'b0; DATAIN = 4'hA; nCTEN = 1'b0;
        step();
        checks++; if (COUNTER !== 4'h0) begin errors++; $display("FAIL pri_clr actual=%h expected=0", COUNTER); end
        CLR = 1'b0; #1;
        checks++; if (MAXMIN !== 1'b0) begin errors++; $display("FAIL pri_mm_up actual=%b expected=0", MAXMIN); end
        DnUP = 1'b1; #1;
        checks++; if (MAXMIN !== 1'b1) begin errors++; $display("FAIL pri_mm_follows_dir actual=%b expected=1", MAXMIN); end
        DnUP = 1'b0;
        step();
        checks++; if (COUNTER !== 4'hA) begin errors++; $display("FAIL pri_loadA actual=%h expected=A", COUNTER); end
    endtask

    task automatic test_load_at_terminal();
        DnUP = 1'b0; nCTEN = 1'b0; nLOAD = 1'b0; DATAIN = 4'hF;
        step();
        checks++; if (COUNTER !== 4'hF) begin errors++; $display("FAIL term_loadF actual=%h expected=F", COUNTER); end
        DATAIN = 4'h3;
        step();
        checks++; if (COUNTER !== 4'h3) begin errors++; $display("FAIL term_load_wins actual=%h expected=3", COUNTER); end
        checks++; if (MAXMIN !== 1'b0) begin errors++; $display("FAIL term_mm_reeval actual=%b expected=0", MAXMIN); end
`ifdef LOGIC_74HC191_STICKY_WRAP_EN
        checks++; if (WRAP !== 1'b0) begin errors++; $display("FAIL term_no_wrap actual=%b expected=0", WRAP); end
`endif
    endtask

    task automatic test_hold_flip();
        logic [3:0] exp_seq [5];
        logic [0:0] dir_seq [5];
        logic [0:0] en_seq  [5];
        exp_seq = '{4'h7, 4'h7, 4'h8, 4'h7, 4'h8};
        dir_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        en_seq  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        nCTEN = 1'b1; nLOAD = 1'b0; DATAIN = 4'h7;
        step();
        nLOAD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nCTEN = en_seq[i][0];
            DnUP  = dir_seq[i][0];
            step();
            chk($sformatf("hold_flip_%0d", i), {4'h0, COUNTER}, {4'h0, exp_seq[i]});
        end
    endtask

    task automatic test_cascade();
        c_dnup = 1'b1; c_cten = 1'b1; c_load = 1'b0; c_data = 8'h10;
        step();
        chk("casc_load", {c2_cnt, c1_cnt}, 8'h10);
        c_load = 1'b0; c_load = 1'b1; c_cten = 1'b0;
        step();
        chk("casc_0F", {c2_cnt, c1_cnt}, 8'h0F);
        repeat (15) step();
        chk("casc_00", {c2_cnt, c1_cnt}, 8'h00);
        step();
        chk("casc_FF", {c2_cnt, c1_cnt}, 8'hFF);
        step();
        chk("casc_FE", {c2_cnt, c1_cnt}, 8'hFE);
    endtask

    initial begin
        checks = 0; errors = 0;
        CLR = 1'b0; nLOAD = 1'b1; nCTEN = 1'b1; DnUP = 1'b0; DATAIN = 4'h0;
        c_clr = 1'b0; c_load = 1'b1; c_cten = 1'b1; c_dnup = 1'b0; c_data = 8'h00;
        #1;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_priority();
        test_load_at_terminal();
        test_hold_flip();
        test_cascade();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
